// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard: tracks in-flight destinations by class and age,
// selects operand bypass sources and stalls decode on RAW/WAW. Optional perf counters: SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NREGS      = 32,
    parameter int MUL_WB_AGE = 5,
    parameter int MEM_WB_AGE = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       adv_i,
    input  logic       issue_en_i,
    input  logic       issue_wr_en_i,
    input  logic [4:0] issue_wr_addr_i,
    input  logic [1:0] issue_class_i,
    input  logic       flush_i,
    input  logic       dec_read_en_a_i,
    input  logic [4:0] dec_read_addr_a_i,
    input  logic       dec_read_en_b_i,
    input  logic [4:0] dec_read_addr_b_i,
    output logic       stall_o,
    output logic [2:0] fwd_sel_a_o,
    output logic [2:0] fwd_sel_b_o,
    output logic [5:0] pending_cnt_o
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0] raw_stall_cnt_o,
    output logic [31:0] waw_stall_cnt_o,
    output logic [31:0] fwd_cnt_o
`endif
);
    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_MUL  = 2'd2;
    localparam logic [2:0] SEL_RF    = 3'd0;
    localparam logic [2:0] SEL_EXE   = 3'd1;
    localparam logic [2:0] SEL_MULT5 = 3'd2;
    localparam logic [2:0] SEL_CACHE = 3'd3;
    localparam logic [2:0] SEL_WB    = 3'd4;
    localparam logic [2:0] MUL_WB    = 3'(MUL_WB_AGE);
    localparam logic [2:0] MEM_WB    = 3'(MEM_WB_AGE);

    logic [NREGS-1:0]      valid_q, valid_d;
    logic [NREGS-1:0][1:0] cls_q, cls_d;
    logic [NREGS-1:0][2:0] age_q, age_d;
    logic [5:0]            cnt_q, cnt_d;

    logic       hit_a, hit_b, raw_a, raw_b, waw, accept;
    logic [2:0] sel_a, sel_b;
    logic [1:0] new_cls;

    function automatic logic [2:0] wb_age(input logic [1:0] c);
        return (c == CLS_MUL) ? MUL_WB : MEM_WB;
    endfunction

    // Returns {raw_stall, sel}; a multiply is only forwardable from M5 onward.
    function automatic logic [3:0] lookup(input logic hit, input logic [1:0] c, input logic [2:0] a);
        logic       stl;
        logic [2:0] sel;
        stl = 1'b0;
        sel = SEL_RF;
        if (hit) begin
            case (c)
                CLS_MUL: begin
                    if (a == MUL_WB)               sel = SEL_WB;
                    else if (a == MUL_WB - 3'd1)   sel = SEL_MULT5;
                    else                           stl = 1'b1;
                end
                CLS_LOAD: begin
                    if (a == 3'd0)                 stl = 1'b1;
                    else if (a == MEM_WB)          sel = SEL_WB;
                    else                           sel = SEL_CACHE;
                end
                default: begin
                    if (a == 3'd0)                 sel = SEL_EXE;
                    else if (a == MEM_WB)          sel = SEL_WB;
                    else                           sel = SEL_CACHE;
                end
            endcase
        end
        return {stl, sel};
    endfunction

    always_comb begin
        hit_a   = dec_read_en_a_i && (dec_read_addr_a_i != 5'd0) && valid_q[dec_read_addr_a_i];
        hit_b   = dec_read_en_b_i && (dec_read_addr_b_i != 5'd0) && valid_q[dec_read_addr_b_i];
        {raw_a, sel_a} = lookup(hit_a, cls_q[dec_read_addr_a_i], age_q[dec_read_addr_a_i]);
        {raw_b, sel_b} = lookup(hit_b, cls_q[dec_read_addr_b_i], age_q[dec_read_addr_b_i]);
        new_cls = (issue_class_i == 2'd3) ? CLS_ALU : issue_class_i;
        // Older producer would write back at or after the newer one: hold the issue.
        waw = issue_en_i && issue_wr_en_i && (issue_wr_addr_i != 5'd0) && valid_q[issue_wr_addr_i]
              && ({1'b0, wb_age(cls_q[issue_wr_addr_i])} >=
                  {1'b0, age_q[issue_wr_addr_i]} + {1'b0, wb_age(new_cls)} + 4'd1);
        stall_o     = !rst_i && !flush_i && (raw_a || raw_b || waw);
        fwd_sel_a_o = rst_i ? SEL_RF : sel_a;
        fwd_sel_b_o = rst_i ? SEL_RF : sel_b;
        accept = issue_en_i && issue_wr_en_i && adv_i && !stall_o && !flush_i
                 && (issue_wr_addr_i != 5'd0);
    end

    always_comb begin
        valid_d = valid_q;
        cls_d   = cls_q;
        age_d   = age_q;
        valid_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (adv_i && valid_q[r]) begin
                if (age_q[r] == wb_age(cls_q[r])) valid_d[r] = 1'b0;
                else                              age_d[r]   = age_q[r] + 3'd1;
            end
            if (accept && (issue_wr_addr_i == 5'(r))) begin
                valid_d[r] = 1'b1;
                cls_d[r]   = new_cls;
                age_d[r]   = 3'd0;
            end
        end
        cnt_d = '0;
        for (int r = 1; r < NREGS; r++) cnt_d = cnt_d + 6'(valid_d[r]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            cls_q   <= '0;
            age_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cls_q   <= cls_d;
            age_q   <= age_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] raw_cnt_q, waw_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_cnt_q <= '0;
            waw_cnt_q <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (!flush_i && (raw_a || raw_b))          raw_cnt_q <= raw_cnt_q + 32'd1;
            if (!flush_i && waw && !(raw_a || raw_b))  waw_cnt_q <= waw_cnt_q + 32'd1;
            if (!stall_o && ((sel_a != SEL_RF) || (sel_b != SEL_RF)))
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign raw_stall_cnt_o = raw_cnt_q;
    assign waw_stall_cnt_o = waw_cnt_q;
    assign fwd_cnt_o       = fwd_cnt_q;
`endif
endmodule
